// File: rtl/conduit_rr_arbiter.sv
// conduit_rr_arbiter
//   Shares one conduit target between NUM_REQ conduit requesters. Requests are
//   arbitrated round-robin. One transaction is in flight at a time. Completion
//   (ack, read data, error) goes back to the granted requester only. A target
//   that never acks is cut off after TIMEOUT ISSUE cycles with an error.
//
// Ports
//   hclk, hresetn            clock, asynchronous active-low reset
//   req_wr/req_rd            per-requester level requests, held until ack
//   req_addr/req_wdata       packed per-requester address / write data
//   req_rdata                shared read data, valid with req_ack
//   req_ack/req_slverr       one-cycle completion pulse / error qualifier
//   tgt_wr/tgt_rd            target strobes, level during ISSUE
//   tgt_addr/tgt_wdata       latched address / write data
//   tgt_rdata/tgt_ack/tgt_slverr  target response
//   grant_id                 current or last granted requester
//   busy                     high while a transaction is in ISSUE or RESP
module conduit_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ-1:0]               req_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [NUM_REQ-1:0]               req_slverr,
  output logic                             tgt_wr,
  output logic                             tgt_rd,
  output logic [ADDR_WIDTH-1:0]            tgt_addr,
  output logic [DATA_WIDTH-1:0]            tgt_wdata,
  input  logic [DATA_WIDTH-1:0]            tgt_rdata,
  input  logic                             tgt_ack,
  input  logic                             tgt_slverr,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [GW:0]   NREQ_W   = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_q, rr_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    dir_q, dir_d;      // 1 = write
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [NUM_REQ-1:0]      pending;
  logic [NUM_REQ-1:0]      rot;
  logic [GW-1:0]           off;
  logic [GW:0]             gsum;
  logic [GW-1:0]           sel;

  // Round-robin pick: rotate the pending vector so rr_q lands at bit 0,
  // take the lowest set bit, then add rr_q back modulo NUM_REQ.
  always_comb begin
    pending = req_wr | req_rd;
    rot     = NUM_REQ'({pending, pending} >> rr_q);
    off     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = GW'(i);
    end
    gsum = {1'b0, rr_q} + {1'b0, off};
    if (gsum >= NREQ_W) gsum = gsum - NREQ_W;
    sel = gsum[GW-1:0];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|pending) begin
          grant_d = sel;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == sel) begin
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              dir_d   = req_wr[i];   // write wins when both are raised
            end
          end
          rr_d    = (sel == LAST_REQ) ? '0 : sel + 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // An ack arriving on the timeout cycle takes priority.
        if (tgt_ack) begin
          if (!dir_q) rdata_d = tgt_rdata;
          err_d   = tgt_slverr;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign tgt_wr     = (state_q == S_ISSUE) &&  dir_q;
  assign tgt_rd     = (state_q == S_ISSUE) && !dir_q;
  assign tgt_addr   = addr_q;
  assign tgt_wdata  = wdata_q;
  assign req_rdata  = rdata_q;
  assign req_ack    = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
  assign req_slverr = (state_q == S_RESP && err_q) ? (NUM_REQ'(1) << grant_q) : '0;
  assign grant_id   = grant_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_conduit_rr_arbiter.sv
module tb_conduit_rr_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [1:0]  req_wr = '0;
  logic [1:0]  req_rd = '0;
  logic [23:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [31:0] req_rdata;
  logic [1:0]  req_ack;
  logic [1:0]  req_slverr;
  logic        tgt_wr;
  logic        tgt_rd;
  logic [11:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [31:0] tgt_rdata = '0;
  logic        tgt_ack = 1'b0;
  logic        tgt_slverr = 1'b0;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int failures = 0;

  conduit_rr_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(12), .TIMEOUT(16)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ack(req_ack), .req_slverr(req_slverr),
    .tgt_wr(tgt_wr), .tgt_rd(tgt_rd), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
    .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack), .tgt_slverr(tgt_slverr),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          done;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [0:0]  gid;
    int          nwr;
    int          nrd;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          unstable;
    int          first_c;
    int          last_c;
    int          ack_c;
  } obs_t;

  // Runs one transaction starting from IDLE. ack_at = strobe cycle number on
  // which the target acks (1 = first ISSUE cycle); 0 means never.
  task automatic do_txn(input logic [1:0] wr, input logic [1:0] rd,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int ack_at, input logic serr, input logic [31:0] rdat,
                        input bit disturb, output obs_t o);
    o = '{default: 0};
    o.first_c = -1;
    req_wr = wr; req_rd = rd; req_addr = {a1, a0}; req_wdata = {d1, d0};
    for (int c = 0; c < 40 && !o.done; c++) begin
      @(posedge hclk); #1;
      tgt_ack = 1'b0; tgt_slverr = 1'b0;
      if (req_ack != 2'b00) begin
        o.done = 1; o.ack = req_ack; o.err = req_slverr; o.rdata = req_rdata;
        o.gid = grant_id; o.ack_c = c;
      end else if (tgt_wr || tgt_rd) begin
        if (o.first_c < 0) begin
          o.first_c = c; o.addr = tgt_addr; o.wdata = tgt_wdata;
          if (disturb) begin
            req_wr = '0; req_rd = '0; req_addr = ~req_addr; req_wdata = ~req_wdata;
          end
        end else if (tgt_addr !== o.addr || tgt_wdata !== o.wdata) begin
          o.unstable = 1;
        end
        o.last_c = c;
        if (tgt_wr) o.nwr++;
        if (tgt_rd) o.nrd++;
        if (o.nwr + o.nrd == ack_at) begin
          tgt_ack = 1'b1; tgt_slverr = serr; tgt_rdata = rdat;
        end
      end
    end
    req_wr = '0; req_rd = '0;
    if (!o.done) begin
      checks++; failures++;
      $display("FAIL txn_complete: no req_ack within 40 cycles, required one");
    end
    @(posedge hclk); #1;
    chk("post_ack_idle", 32'({busy, req_ack}), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  wr, rd;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    int          ack_at;
    logic        serr;
    logic [31:0] rdat;
    bit          disturb;
    int          eg;
    bit          ew;
    logic [1:0]  eerr;
    logic [31:0] erd;
    int          estr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    obs_t o;
    string p;
    logic [11:0] ea;
    int n, prev, ptr, g, ack_at, estr;
    logic [1:0] wr, rd, pend, eerr;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1, rdat, mrd;
    logic serr;
    bit isw, to;

    //           wr     rd     a0      a1      d0            d1            ack serr rdat          dist eg ew eerr   erd           estr
    vecs[0] = '{2'b01, 2'b00, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0, 1, 2'b00, 32'h0,        1};
    vecs[1] = '{2'b00, 2'b10, 12'h000, 12'h020, 32'h0,        32'h0,        3, 0, 32'h12345678, 0, 1, 0, 2'b00, 32'h12345678, 3};
    vecs[2] = '{2'b00, 2'b10, 12'h000, 12'h030, 32'h0,        32'h0,        2, 1, 32'h0BADF00D, 0, 1, 0, 2'b10, 32'h0BADF00D, 2};
    vecs[3] = '{2'b11, 2'b00, 12'h044, 12'h088, 32'h11112222, 32'h33334444, 1, 0, 32'h0,        0, 0, 1, 2'b00, 32'h0BADF00D, 1};
    vecs[4] = '{2'b01, 2'b01, 12'h0FF, 12'h000, 32'hCAFEF00D, 32'h0,        4, 0, 32'h99999999, 1, 0, 1, 2'b00, 32'h0BADF00D, 4};
    vecs[5] = '{2'b00, 2'b11, 12'h111, 12'hABC, 32'h0,        32'h0,        1, 0, 32'h5A5A5A5A, 0, 1, 0, 2'b00, 32'h5A5A5A5A, 1};
    vecs[6] = '{2'b10, 2'b01, 12'h123, 12'h456, 32'h0,        32'h77777777, 1, 0, 32'h00000001, 0, 0, 0, 2'b00, 32'h00000001, 1};
    vecs[7] = '{2'b10, 2'b01, 12'h124, 12'h457, 32'h0,        32'h88888888, 2, 1, 32'h55555555, 0, 1, 1, 2'b10, 32'h00000001, 2};

    // Reset state
    #12;
    chk("reset_outputs", 32'({req_ack, req_slverr, tgt_wr, tgt_rd, grant_id, busy}), 32'd0);
    chk("reset_rdata", req_rdata, 32'd0);
    chk("reset_tgt_bus", 32'(tgt_addr) | tgt_wdata, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].wr, vecs[i].rd, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
             vecs[i].ack_at, vecs[i].serr, vecs[i].rdat, vecs[i].disturb, o);
      p = $sformatf("vec%0d", i);
      chk({p, "_ack"}, 32'(o.ack), 32'(1 << vecs[i].eg));
      chk({p, "_gid"}, 32'(o.gid), 32'(vecs[i].eg));
      chk({p, "_slverr"}, 32'(o.err), 32'(vecs[i].eerr));
      chk({p, "_rdata"}, o.rdata, vecs[i].erd);
      chk({p, "_nwr"}, 32'(o.nwr), vecs[i].ew ? 32'(vecs[i].estr) : 32'd0);
      chk({p, "_nrd"}, 32'(o.nrd), vecs[i].ew ? 32'd0 : 32'(vecs[i].estr));
      chk({p, "_addr"}, 32'(o.addr), 32'(vecs[i].eg == 1 ? vecs[i].a1 : vecs[i].a0));
      if (vecs[i].ew)
        chk({p, "_wdata"}, o.wdata, vecs[i].eg == 1 ? vecs[i].d1 : vecs[i].d0);
      chk({p, "_stable"}, 32'(o.unstable), 32'd0);
      chk({p, "_strobe_lat"}, 32'(o.first_c), 32'd0);
      chk({p, "_ack_lat"}, 32'(o.ack_c), 32'(o.last_c + 1));
    end

    // Target never acks: 16 strobe cycles, error, zero data; next is normal
    do_txn(2'b00, 2'b01, 12'h055, 12'h000, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 0, o);
    chk("to_nrd", 32'(o.nrd), 32'd16);
    chk("to_ack", 32'(o.ack), 32'h1);
    chk("to_slverr", 32'(o.err), 32'h1);
    chk("to_rdata", o.rdata, 32'h0);
    do_txn(2'b00, 2'b10, 12'h000, 12'h066, 32'h0, 32'h0, 1, 0, 32'h00000077, 0, o);
    chk("after_to_ack", 32'(o.ack), 32'h2);
    chk("after_to_slverr", 32'(o.err), 32'h0);
    chk("after_to_rdata", o.rdata, 32'h77);

    // Ack on the timeout cycle: target response wins
    do_txn(2'b00, 2'b01, 12'h070, 12'h000, 32'h0, 32'h0, 16, 0, 32'h0000ABCD, 0, o);
    chk("acktime0_nrd", 32'(o.nrd), 32'd16);
    chk("acktime0_slverr", 32'(o.err), 32'h0);
    chk("acktime0_rdata", o.rdata, 32'h0000ABCD);
    do_txn(2'b00, 2'b10, 12'h000, 12'h071, 32'h0, 32'h0, 16, 1, 32'h00001234, 0, o);
    chk("acktime1_ack", 32'(o.ack), 32'h2);
    chk("acktime1_slverr", 32'(o.err), 32'h2);
    chk("acktime1_rdata", o.rdata, 32'h00001234);

    // tgt_ack while idle is ignored
    tgt_ack = 1'b1; tgt_slverr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge hclk); #1;
      chk($sformatf("idle_ack%0d", c), 32'({busy, req_ack, req_slverr}), 32'd0);
    end
    tgt_ack = 1'b0; tgt_slverr = 1'b0;

    // Reset asserted mid-ISSUE
    req_rd = 2'b01; req_addr = {12'h0, 12'h0C0};
    for (int c = 0; c < 3; c++) begin
      @(posedge hclk); #1;
    end
    chk("pre_reset_strobe", 32'(tgt_rd), 32'd1);
    #2 hresetn = 1'b0;
    #1;
    chk("async_reset", 32'({tgt_wr, tgt_rd, req_ack, busy, grant_id}), 32'd0);
    @(posedge hclk); #1;
    chk("held_reset", 32'({tgt_wr, tgt_rd, req_ack, busy}), 32'd0);
    req_rd = 2'b00;
    hresetn = 1'b1;
    do_txn(2'b00, 2'b10, 12'h000, 12'h0AA, 32'h0, 32'h0, 1, 0, 32'h00000AAA, 0, o);
    chk("post_reset_gid", 32'(o.gid), 32'd1);
    chk("post_reset_addr", 32'(o.addr), 32'h0AA);

    // Fairness with both requesters continuously writing
    req_wr = 2'b11; req_addr = {12'h200, 12'h100}; req_wdata = {32'h2, 32'h1};
    n = 0; prev = -1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(posedge hclk); #1;
      tgt_ack = 1'b0;
      if (req_ack != 2'b00) begin
        chk($sformatf("fair%0d_ack", n), 32'(req_ack), (n % 2 == 1) ? 32'h2 : 32'h1);
        chk($sformatf("fair%0d_gid", n), 32'(grant_id), 32'(n % 2));
        if (prev >= 0) chk($sformatf("fair%0d_spacing", n), 32'(c - prev), 32'd3);
        prev = c; n++;
      end else if (tgt_wr) begin
        ea = (n % 2 == 1) ? 12'h200 : 12'h100;
        chk($sformatf("fair%0d_addr", n), 32'(tgt_addr), 32'(ea));
        tgt_ack = 1'b1;
      end
    end
    req_wr = 2'b00;
    chk("fair_count", 32'(n), 32'd6);
    @(posedge hclk); #1;

    // Randomized transactions against a reference model
    hresetn = 1'b0; #1;
    chk("rand_reset_rdata", req_rdata, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    ptr = 0; mrd = '0;
    for (int t = 0; t < 40; t++) begin
      wr = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      if ((wr | rd) == 2'b00) rd = 2'b01;
      a0 = 12'($urandom); a1 = 12'($urandom);
      d0 = $urandom; d1 = $urandom; rdat = $urandom;
      ack_at = int'($urandom_range(0, 18));
      serr = 1'($urandom_range(0, 1));
      pend = wr | rd;
      g = -1;
      for (int k = 0; k < 2; k++)
        if (g < 0 && ((pend >> ((ptr + k) % 2)) & 2'b01) != 2'b00) g = (ptr + k) % 2;
      isw = ((wr >> g) & 2'b01) != 2'b00;
      to = !(ack_at >= 1 && ack_at <= 16);
      estr = to ? 16 : ack_at;
      eerr = (to || serr) ? 2'(1 << g) : 2'b00;
      if (to) mrd = '0;
      else if (!isw) mrd = rdat;
      ptr = (g + 1) % 2;

      do_txn(wr, rd, a0, a1, d0, d1, ack_at, serr, rdat, 0, o);
      p = $sformatf("rand%0d", t);
      chk({p, "_ack"}, 32'(o.ack), 32'(1 << g));
      chk({p, "_slverr"}, 32'(o.err), 32'(eerr));
      if (!(to && isw)) chk({p, "_rdata"}, o.rdata, mrd);
      chk({p, "_strobes"}, 32'(isw ? o.nwr : o.nrd), 32'(estr));
      chk({p, "_addr"}, 32'(o.addr), 32'(g == 1 ? a1 : a0));
      if (isw) chk({p, "_wdata"}, o.wdata, g == 1 ? d1 : d0);
      // A timed-out write has no defined read-data result; resync the model.
      if (to && isw) mrd = o.rdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conduit_rr_arbiter.md
Name: conduit_rr_arbiter

Overview:
Shares one conduit-backed target (register bank or memory) between NUM_REQ conduit requesters, typically several AHB slave adapters. Arbitration is round-robin. The block issues one transaction at a time, then returns ack, read data and error to the granted requester only. A hung target is broken by a timeout counter, which completes the access with an error.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 12, address width
TIMEOUT, 16, cycles to wait for tgt_ack before forcing an error completion (>=2)

Ports:
hclk  in  1  clock
hresetn  in  1  reset, asynchronous, active-low
req_wr  in  NUM_REQ  per-requester write request, level, held until ack
req_rd  in  NUM_REQ  per-requester read request, level, held until ack
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_rdata  out  DATA_WIDTH  read data, shared, valid with req_ack
req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
req_slverr  out  NUM_REQ  error qualifier, valid only with req_ack
tgt_wr  out  1  target write strobe, level
tgt_rd  out  1  target read strobe, level
tgt_addr  out  ADDR_WIDTH  target address
tgt_wdata  out  DATA_WIDTH  target write data
tgt_rdata  in  DATA_WIDTH  target read data, sampled with tgt_ack
tgt_ack  in  1  target completion
tgt_slverr  in  1  target error, sampled with tgt_ack
grant_id  out  $clog2(NUM_REQ)  index of current or last grant
busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, rr_ptr=0, timeout counter=0, latched addr/wdata/dir=0. Reset mid-transfer aborts immediately with no ack.
- Requester i is pending if req_wr[i] or req_rd[i] is high. If both are high, the access is treated as a write.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - With no pending requester, stay in IDLE.
  - Otherwise, grant the first pending index searching from rr_ptr upward, modulo NUM_REQ.
  - Register grant_id, address, wdata and direction, then go to ISSUE.
  - Set rr_ptr to (grant+1) mod NUM_REQ.
- ISSUE:
  - tgt_wr or tgt_rd is high according to the latched direction. tgt_addr/tgt_wdata come from the latched values, stable for the whole state.
  - The timeout counter increments each cycle.
  - On tgt_ack: register tgt_rdata (reads only; writes leave req_rdata unchanged) and tgt_slverr, then go to RESP.
  - If the counter reaches TIMEOUT-1 without tgt_ack: go to RESP with slverr=1 and rdata=0.
  - Strobes drop in RESP.
- RESP, exactly one cycle:
  - req_ack[grant_id]=1 and req_slverr[grant_id]=latched error; all other requesters see 0.
  - Counter clears. Return to IDLE.
- Latency: request seen in IDLE at cycle 0 gives strobe in cycle 1. A target ack in cycle k gives req_ack in cycle k+1. Minimum turnaround is 3 cycles per transaction, with no back-to-back overlap.
- Requester rules:
  - A requester must drop its request in the cycle after req_ack. The requester is only sampled in IDLE, so re-arbitration cannot see a stale request.
  - Request changes during ISSUE (drop, address change) are ignored. The latched transaction completes and is acked anyway.
- tgt_ack outside ISSUE is ignored.
- tgt_ack in the same cycle the timeout would fire: the ack wins and its slverr is used.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1, so no requester waits more than NUM_REQ-1 transactions.
- req_rdata holds its last value between read completions.

Test Plan:
- Single write, requester 0, addr 0x010, data 0xDEADBEEF, target acks in 1st ISSUE cycle -> tgt_wr high 1 cycle with those values; req_ack=2'b01 the cycle after; req_slverr=0.
- Read from requester 1, addr 0x020, target acks after 3 cycles with rdata 0x12345678 -> tgt_rd high 3 cycles; req_rdata=0x12345678 with req_ack=2'b10.
- Both requesters continuously requesting writes, 6 transactions -> grant_id sequence 0,1,0,1,0,1; each req_ack one-hot and matching grant.
- Target never acks, TIMEOUT=16 -> strobe high exactly 16 cycles; req_ack with req_slverr=1 and req_rdata=0; next transaction proceeds normally.
- Target acks with tgt_slverr=1 on read from requester 1 -> req_slverr=2'b10 with req_ack=2'b10. Separately, ack and timeout in the same cycle -> slverr follows tgt_slverr.
- hresetn asserted during ISSUE -> strobes, acks and busy go 0 asynchronously. After release, a pending requester 1 is granted first (rr_ptr=0, requester 0 idle).
